// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types, including the memory-port arbiter state.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_SERVE_IF,
    ARB_SERVE_MEM
  } lc3b_arb_state;

  // Streak counter width; covers the legal STREAK_MAX range 1..15.
  localparam int ARB_STREAK_W = 4;

endpackage

// File: rtl/mux2.sv
// Generic two-input multiplexer.
// Latency: combinational.
// Backpressure: none.
module mux2 #(
  parameter int WIDTH = 16
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] f
);

  assign f = sel ? b : a;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one physical memory port between the fetch (if_*) and data (mem_*) ports.
// Latency: request seen in IDLE -> pmem strobe next cycle; pmem_resp routed to x_resp same cycle.
// Backpressure: losing port simply holds its request; data wins ties, but fetch wins after STREAK_MAX data grants.
module mem_port_arbiter
  import lc3b_types::*;
#(
  parameter int STREAK_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,

  input  logic          if_read,
  input  logic          if_write,
  input  lc3b_mem_wmask if_wmask,
  input  lc3b_word      if_address,
  input  lc3b_word      if_wdata,
  output logic          if_resp,
  output lc3b_word      if_rdata,

  input  logic          mem_read,
  input  logic          mem_write,
  input  lc3b_mem_wmask mem_wmask,
  input  lc3b_word      mem_address,
  input  lc3b_word      mem_wdata,
  output logic          mem_resp,
  output lc3b_word      mem_rdata,

  output logic          pmem_read,
  output logic          pmem_write,
  output lc3b_mem_wmask pmem_wmask,
  output lc3b_word      pmem_address,
  output lc3b_word      pmem_wdata,
  input  logic          pmem_resp,
  input  lc3b_word      pmem_rdata
);

  localparam logic [ARB_STREAK_W-1:0] STREAK_LIM = ARB_STREAK_W'(STREAK_MAX);

  lc3b_arb_state           state;
  logic [ARB_STREAK_W-1:0] streak;

  logic          if_req;
  logic          mem_req;
  logic          serve_if;
  logic          serve_mem;
  logic          busy;
  lc3b_word      sel_address;
  lc3b_word      sel_wdata;
  lc3b_mem_wmask sel_wmask;

  assign if_req    = if_read | if_write;
  assign mem_req   = mem_read | mem_write;
  assign serve_if  = (state == ARB_SERVE_IF);
  assign serve_mem = (state == ARB_SERVE_MEM);
  assign busy      = serve_if | serve_mem;

  // Port select: fetch when serving fetch, otherwise data; zeroed below when idle.
  mux2 #(.WIDTH(16)) address_mux (.sel(serve_if), .a(mem_address), .b(if_address), .f(sel_address));
  mux2 #(.WIDTH(16)) wdata_mux   (.sel(serve_if), .a(mem_wdata),   .b(if_wdata),   .f(sel_wdata));
  mux2 #(.WIDTH(2))  wmask_mux   (.sel(serve_if), .a(mem_wmask),   .b(if_wmask),   .f(sel_wmask));

  assign pmem_address = busy ? sel_address : '0;
  assign pmem_wdata   = busy ? sel_wdata   : '0;
  assign pmem_wmask   = busy ? sel_wmask   : '0;

  // Strobes follow the granted port live, so a withdrawn request drops them while the grant holds.
  assign pmem_read  = (serve_if & if_read)  | (serve_mem & mem_read);
  assign pmem_write = (serve_if & if_write) | (serve_mem & mem_write);

  // A stray pmem_resp while idle reaches neither port.
  assign if_resp   = serve_if  & pmem_resp;
  assign mem_resp  = serve_mem & pmem_resp;
  assign if_rdata  = pmem_rdata;
  assign mem_rdata = pmem_rdata;

  // Grant FSM and starvation counter; every grant returns through IDLE for one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ARB_IDLE;
      streak <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (if_req && mem_req) begin
            if (streak < STREAK_LIM) begin
              state  <= ARB_SERVE_MEM;
              streak <= streak + ARB_STREAK_W'(1);
            end else begin
              state  <= ARB_SERVE_IF;
              streak <= '0;
            end
          end else if (mem_req) begin
            state <= ARB_SERVE_MEM;
          end else if (if_req) begin
            state  <= ARB_SERVE_IF;
            streak <= '0;
          end
        end
        ARB_SERVE_IF, ARB_SERVE_MEM: begin
          if (pmem_resp) state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // Read and write together on one port is a requester bug; pmem still sees both strobes.
  if_rw_exclusive: assert property (@(posedge clk) disable iff (reset) !(if_read && if_write));
  mem_rw_exclusive: assert property (@(posedge clk) disable iff (reset) !(mem_read && mem_write));

endmodule
